// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer built around one shared WIDTH-bit add/sub datapath.
// MUL is shift-add, DIV is restoring division; result/sgn/err are registered and held.
`timescale 1ns/1ps
module calc_op_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 sgn,
  output logic                 err
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_inv;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   neg_diff;
  logic [2*WIDTH-1:0] shl;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] res_next;
  logic               sgn_next;
  logic               div_ok;
  logic               last;

  always_comb begin
    shl     = {acc[2*WIDTH-2:0], 1'b0};
    add_x   = a_q;
    add_y   = b_q;
    add_inv = 1'b0;
    unique case (op_q)
      OP_SUB: add_inv = 1'b1;
      OP_MUL: begin
        add_x = acc[2*WIDTH-1:WIDTH];
        add_y = a_q;
      end
      OP_DIV: begin
        add_x   = shl[2*WIDTH-1:WIDTH];
        add_inv = 1'b1;
      end
      default: ;
    endcase
    add_sum  = {1'b0, add_x} + {1'b0, add_y ^ {WIDTH{add_inv}}} + {{WIDTH{1'b0}}, add_inv};
    neg_diff = ~add_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
    // The bit shifted out of R means R >= 2^WIDTH > b, so the trial subtract
    // succeeds even though the W-bit adder reports a borrow.
    div_ok   = add_sum[WIDTH] | acc[2*WIDTH-1];

    acc_next = acc;
    if (op_q == OP_MUL) begin
      acc_next = b_q[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end else if (op_q == OP_DIV) begin
      acc_next = {(div_ok ? add_sum[WIDTH-1:0] : shl[2*WIDTH-1:WIDTH]), shl[WIDTH-1:1], div_ok};
    end

    res_next = acc_next;
    sgn_next = 1'b1;
    if (op_q == OP_ADD) begin
      res_next = {{(WIDTH-1){1'b0}}, add_sum};
    end else if (op_q == OP_SUB) begin
      res_next = {{WIDTH{1'b0}}, (add_sum[WIDTH] ? add_sum[WIDTH-1:0] : neg_diff)};
      sgn_next = add_sum[WIDTH];
    end

    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      sgn    <= 1'b1;
      err    <= 1'b0;
      cnt    <= '0;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && ready) begin
            op_q   <= op_t'(op);
            a_q    <= a;
            b_q    <= b;
            acc    <= (op == 2'b11) ? {{WIDTH{1'b0}}, a} : '0;
            cnt    <= '0;
            result <= '0;
            sgn    <= 1'b1;
            err    <= 1'b0;
            ready  <= 1'b0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            result <= res_next;
            sgn    <= sgn_next;
            done   <= 1'b1;
            state  <= DONE;
          end else if (op_q == OP_DIV && b_q == '0) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc <= acc_next;
            // The multiplier is consumed LSB-first by shifting it down each step.
            if (op_q == OP_MUL) b_q <= b_q >> 1;
            if (last) begin
              result <= res_next;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed cases plus a shuffled sweep of every
// op/operand combination against an arithmetic reference model.
`timescale 1ns/1ps
module tb_calc_op_sequencer;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           done;
  logic [2*W-1:0] result;
  logic           sgn;
  logic           err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .sgn(sgn), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic void model(input logic [1:0] o, input int x, input int y,
                                output int r, output int s, output int e, output int l);
    s = 1; e = 0; l = 1; r = 0;
    case (o)
      2'd0: r = x + y;
      2'd1: if (x >= y) r = x - y; else begin r = y - x; s = 0; end
      2'd2: begin r = x * y; l = W; end
      default: if (y == 0) e = 1; else begin r = ((x % y) << W) + (x / y); l = W; end
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit hold);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    chk("accept_ready", ready, 0);
    chk("accept_done", done, 0);
    chk("accept_result_clr", result, 0);
    chk("accept_sgn_clr", sgn, 1);
    chk("accept_err_clr", err, 0);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      chk("busy_ready", ready, 0);
      if (done === 1'b1) got = 1'b1;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit hold);
    int r, s, e, l;
    bit got;
    model(o, int'(x), int'(y), r, s, e, l);
    launch(o, x, y, hold);
    wait_done(got);
    chk("latency", cyc, l);
    chk("result", result, r);
    chk("sgn", sgn, s);
    chk("err", err, e);
    tick();
    chk("post_ready", ready, 1);
    chk("post_done", done, 0);
    chk("post_result_held", result, r);
    start = 1'b0;
  endtask

  initial begin
    int extra, off, k;
    bit got;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_sgn", sgn, 1);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 4'd9, 4'd8, 1'b0);
    run_op(2'd1, 4'd3, 4'd7, 1'b0);
    run_op(2'd1, 4'd7, 4'd7, 1'b0);

    // MUL 15*15 with a stray start pulse sampled at edge N+2.
    launch(2'd2, 4'd15, 4'd15, 1'b0);
    tick();
    chk("mul_n1_done", done, 0);
    start = 1'b1;
    tick();
    chk("mul_n2_done", done, 0);
    start = 1'b0;
    wait_done(got);
    chk("mul_latency", cyc, 4);
    chk("mul_result", result, 8'hE1);
    extra = 0;
    repeat (6) begin tick(); if (done === 1'b1) extra++; end
    chk("mul_no_second_done", extra, 0);
    chk("mul_idle_ready", ready, 1);

    run_op(2'd3, 4'd13, 4'd4, 1'b0);
    run_op(2'd3, 4'd9, 4'd0, 1'b0);

    // Reset in the middle of MUL 5*6.
    launch(2'd2, 4'd5, 4'd6, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_sgn", sgn, 1);
    chk("abort_err", err, 0);
    extra = 0;
    repeat (6) begin tick(); if (done === 1'b1) extra++; end
    chk("abort_no_done", extra, 0);
    run_op(2'd0, 4'd1, 4'd1, 1'b0);

    // Every op/operand combination, visited in a random odd-stride order.
    off = int'($urandom_range(0, 1023));
    for (int i = 0; i < 1024; i++) begin
      k = (i * 389 + off) % 1024;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(k[9:8], k[7:4], k[3:0], ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
